uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an internal transmit FIFO, configurable data width, parity and stop-bit count, and XOR obfuscation of each word. Upstream writes words with wr_en whenever the block is not full. The block serialises frames back-to-back on tx, paced by an externally generated one-cycle baud_tick1 pulse. It sits between the system write path and the serial pad.

---
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a registered TX FIFO; every word is XOR-obfuscated before framing.
// Define TX_BREAK_EN to add the send_break input and the BREAK state.
module uart_tx_fifo #(
  parameter int         DATA_W      = 8,
  parameter int         FIFO_DEPTH  = 4,
  parameter bit         PARITY_EN   = 1'b1,
  parameter bit         PARITY_TYPE = 1'b0,
  parameter int         STOP_BITS   = 1,
  parameter logic [7:0] XOR_KEY     = 8'h45
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        baud_tick1,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           data_in,
`ifdef TX_BREAK_EN
  input  logic                        send_break,
`endif
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        tx,
  output logic                        busy
);

  // state  | meaning
  // IDLE   | line high, waiting for FIFO data (or a break request)
  // START  | word loaded; next tick sends the start bit
  // DATA   | each tick sends shift_q[idx_q], LSB first
  // PARITY | next tick sends the parity bit
  // STOP   | each tick sends a stop bit; leaves after STOP_BITS ticks
  // BREAK  | line held low while send_break stays high
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef TX_BREAK_EN
    , S_BREAK
`endif
  } state_e;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] KEY     = DATA_W'(XOR_KEY);
  localparam logic [IW-1:0]     LAST    = IW'(DATA_W - 1);
  localparam logic [AW:0]       DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                stop_q, stop_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                ovf_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         level_q, level_d;
  logic                push, pop;

  // Admission uses the registered occupancy only, so a same-cycle pop never frees a slot early.
  assign full     = (level_q == DEPTH_L);
  assign push     = wr_en && !full;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
`ifdef TX_BREAK_EN
        if (send_break) begin
          state_d = S_BREAK;
          busy_d  = 1'b1;
        end else
`endif
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q] ^ KEY;
          idx_d   = '0;
          stop_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (baud_tick1) begin
        tx_d    = 1'b0;
        state_d = S_DATA;
      end
      S_DATA: if (baud_tick1) begin
        tx_d = shift_q[idx_q];
        if (idx_q == LAST) state_d = PARITY_EN ? S_PARITY : S_STOP;
        else               idx_d   = idx_q + 1'b1;
      end
      S_PARITY: if (baud_tick1) begin
        tx_d    = (^shift_q) ^ PARITY_TYPE;
        state_d = S_STOP;
      end
      S_STOP: if (baud_tick1) begin
        tx_d = 1'b1;
        if (STOP_BITS == 1 || stop_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          stop_d = 1'b1;
        end
      end
`ifdef TX_BREAK_EN
      S_BREAK: if (baud_tick1) begin
        if (send_break) begin
          tx_d = 1'b0;
        end else begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= wr_en && full;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations checked every cycle against a frame-list model,
// plus literal per-tick line captures. Break scenario runs when TX_BREAK_EN is defined.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst, baud_tick1, baud_en;
  logic wr_a, wr_b, wr_c, sb_a;
  logic [7:0] din_a, din_c;
  logic [6:0] din_b;
  logic tx_a, busy_a, full_a, ovf_a;
  logic tx_b, busy_b, full_b, ovf_b;
  logic tx_c, busy_c, full_c, ovf_c;
  logic [2:0] lvl_a, lvl_b, lvl_c;
  int n_cmp = 0;
  int n_err = 0;
  int bcnt;

  always #5 clk = ~clk;

  uart_tx_fifo u_a (
    .clk(clk), .rst(rst), .baud_tick1(baud_tick1), .wr_en(wr_a), .data_in(din_a),
`ifdef TX_BREAK_EN
    .send_break(sb_a),
`endif
    .full(full_a), .level(lvl_a), .overflow(ovf_a), .tx(tx_a), .busy(busy_a));

  uart_tx_fifo #(.DATA_W(7), .PARITY_EN(1'b0), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .baud_tick1(baud_tick1), .wr_en(wr_b), .data_in(din_b),
`ifdef TX_BREAK_EN
    .send_break(1'b0),
`endif
    .full(full_b), .level(lvl_b), .overflow(ovf_b), .tx(tx_b), .busy(busy_b));

  uart_tx_fifo #(.PARITY_TYPE(1'b1)) u_c (
    .clk(clk), .rst(rst), .baud_tick1(baud_tick1), .wr_en(wr_c), .data_in(din_c),
`ifdef TX_BREAK_EN
    .send_break(1'b0),
`endif
    .full(full_c), .level(lvl_c), .overflow(ovf_c), .tx(tx_c), .busy(busy_c));

  // Model: FIFO as a circular list; an active frame is a list of line bits, one consumed per tick.
  int   p_dw[3]  = '{8, 7, 8};
  bit   p_pen[3] = '{1'b1, 1'b0, 1'b1};
  bit   p_pt[3]  = '{1'b0, 1'b0, 1'b1};
  int   p_sb[3]  = '{1, 2, 1};
  logic [8:0] m_mem[3][4];
  int   m_head[3], m_cnt[3], m_nb[3], m_pos[3];
  logic m_bits[3][16];
  logic m_busy[3], m_tx[3], m_ovf[3], m_brk[3];
  logic started = 1'b0;
  logic tick_rec = 1'b0;

  // Per-tick line capture (only ticks landing while a frame/break was in progress).
  logic ltx[3][256];
  logic lb[3][256];
  int   nlog[3] = '{0, 0, 0};
  int   base[3] = '{0, 0, 0};
  logic bl[3] = '{1'b0, 1'b0, 1'b0};

  int e1[11] = '{0,0,0,0,0,0,1,1,1,1,1};
  int e2[5]  = '{8'h44, 8'h47, 8'h46, 8'h41, 8'h40};
  int e3[20] = '{0,0,1,0,1,1,1,1,1,1, 0,1,0,1,0,0,0,1,1,1};
  int e4[11] = '{0,0,0,0,0,0,0,0,0,1,1};
  int e6[15] = '{0,0,0,1, 0,1,0,1,0,1,0,1,0,0,1};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input logic w, input logic [8:0] din, input logic brk);
    int cnt0;
    int n;
    logic [8:0] mask;
    logic [8:0] word;
    cnt0 = m_cnt[d];
    if (rst) begin
      m_cnt[d] = 0; m_head[d] = 0; m_busy[d] = 1'b0; m_brk[d] = 1'b0;
      m_tx[d] = 1'b1; m_ovf[d] = 1'b0;
      return;
    end
    m_ovf[d] = w && (cnt0 == 4);
    if (w && cnt0 != 4) begin
      m_mem[d][(m_head[d] + cnt0) % 4] = din;
      m_cnt[d] = m_cnt[d] + 1;
    end
    if (m_busy[d]) begin
      if (baud_tick1) begin
        if (m_brk[d]) begin
          if (brk) m_tx[d] = 1'b0;
          else begin m_tx[d] = 1'b1; m_busy[d] = 1'b0; m_brk[d] = 1'b0; end
        end else begin
          m_tx[d] = m_bits[d][m_pos[d]];
          m_pos[d] = m_pos[d] + 1;
          if (m_pos[d] == m_nb[d]) m_busy[d] = 1'b0;
        end
      end
    end else if (brk) begin
      m_busy[d] = 1'b1;
      m_brk[d]  = 1'b1;
    end else if (cnt0 != 0) begin
      mask = 9'((1 << p_dw[d]) - 1);
      word = (m_mem[d][m_head[d]] ^ 9'h045) & mask;
      m_bits[d][0] = 1'b0;
      for (int i = 0; i < p_dw[d]; i++) m_bits[d][1 + i] = word[i];
      n = 1 + p_dw[d];
      if (p_pen[d]) begin m_bits[d][n] = (^word) ^ p_pt[d]; n++; end
      for (int s = 0; s < p_sb[d]; s++) begin m_bits[d][n] = 1'b1; n++; end
      m_nb[d] = n; m_pos[d] = 0; m_busy[d] = 1'b1;
      m_head[d] = (m_head[d] + 1) % 4;
      m_cnt[d] = m_cnt[d] - 1;
    end
  endtask

  task automatic cmp_dut(input int d, input logic t, input logic b, input logic [2:0] l,
                         input logic f, input logic o);
    check($sformatf("tx%0d", d),    int'(t), int'(m_tx[d]));
    check($sformatf("busy%0d", d),  int'(b), int'(m_busy[d]));
    check($sformatf("level%0d", d), int'(l), m_cnt[d]);
    check($sformatf("full%0d", d),  int'(f), int'(m_cnt[d] == 4));
    check($sformatf("ovf%0d", d),   int'(o), int'(m_ovf[d]));
  endtask

  task automatic log_one(input int d, input logic t, input logic b);
    if (tick_rec && bl[d] && nlog[d] < 256) begin
      ltx[d][nlog[d]] = t;
      lb[d][nlog[d]]  = b;
      nlog[d] = nlog[d] + 1;
    end
    bl[d] = b;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_log(input int d, input int n, input int budget);
    int c;
    c = 0;
    while (nlog[d] - base[d] < n && c < budget) begin @(posedge clk); #1; c++; end
    check($sformatf("wait_log%0d", d), int'(nlog[d] - base[d] >= n), 1);
  endtask

  initial begin
    baud_tick1 = 1'b0;
    bcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (baud_en) begin bcnt++; baud_tick1 = (bcnt % 16 == 0); end
      else begin bcnt = 0; baud_tick1 = 1'b0; end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      tick_rec = baud_tick1;
      model_step(0, wr_a, {1'b0, din_a}, sb_a);
      model_step(1, wr_b, {2'b0, din_b}, 1'b0);
      model_step(2, wr_c, {1'b0, din_c}, 1'b0);
      started = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        cmp_dut(0, tx_a, busy_a, lvl_a, full_a, ovf_a);
        cmp_dut(1, tx_b, busy_b, lvl_b, full_b, ovf_b);
        cmp_dut(2, tx_c, busy_c, lvl_c, full_c, ovf_c);
      end
      log_one(0, tx_a, busy_a);
      log_one(1, tx_b, busy_b);
      log_one(2, tx_c, busy_c);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; baud_en = 1'b0; sb_a = 1'b0;
    wr_a = 1'b0; wr_b = 1'b0; wr_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    step(3);
    check("rst_tx", int'(tx_a), 1);
    check("rst_busy", int'(busy_a), 0);
    check("rst_level", int'(lvl_a), 0);
    check("rst_full", int'(full_a), 0);
    check("rst_ovf", int'(ovf_a), 0);
    rst = 1'b0;
    step(2);

    // Single frame, default parameters
    din_a = 8'hA5; wr_a = 1'b1; step(1); wr_a = 1'b0; step(2);
    base[0] = nlog[0]; baud_en = 1'b1;
    wait_log(0, 11, 400);
    for (int i = 0; i < 11; i++) check("t1_bit", int'(ltx[0][base[0] + i]), e1[i]);
    check("t1_busy_parity", int'(lb[0][base[0] + 9]), 1);
    check("t1_busy_stop", int'(lb[0][base[0] + 10]), 0);
    baud_en = 1'b0; step(3);

    // Fill to full, drop the sixth write, then drain five frames
    for (int k = 1; k <= 6; k++) begin
      din_a = 8'(k); wr_a = 1'b1; step(1);
      if (k == 5) begin
        check("t2_level", int'(lvl_a), 4);
        check("t2_full", int'(full_a), 1);
      end
      if (k == 6) check("t2_ovf_pulse", int'(ovf_a), 1);
    end
    wr_a = 1'b0; step(1);
    check("t2_ovf_clear", int'(ovf_a), 0);
    base[0] = nlog[0]; baud_en = 1'b1;
    wait_log(0, 55, 1500);
    for (int f = 0; f < 5; f++) begin
      int w;
      int bs;
      w = 0;
      bs = base[0] + f * 11;
      for (int i = 0; i < 8; i++) w = w | (int'(ltx[0][bs + 1 + i]) << i);
      check("t2_word", w, e2[f]);
      check("t2_start", int'(ltx[0][bs]), 0);
      check("t2_stop", int'(ltx[0][bs + 10]), 1);
    end
    baud_en = 1'b0; step(3);

    // 7 data bits, no parity, two stop bits, two frames
    din_b = 7'h3F; wr_b = 1'b1; step(1);
    din_b = 7'h00; step(1); wr_b = 1'b0; step(2);
    base[1] = nlog[1]; baud_en = 1'b1;
    wait_log(1, 20, 600);
    for (int i = 0; i < 20; i++) check("t3_bit", int'(ltx[1][base[1] + i]), e3[i]);
    baud_en = 1'b0; step(3);

    // Odd parity over an all-zero encrypted word
    din_c = 8'h45; wr_c = 1'b1; step(1); wr_c = 1'b0; step(2);
    base[2] = nlog[2]; baud_en = 1'b1;
    wait_log(2, 11, 400);
    for (int i = 0; i < 11; i++) check("t4_bit", int'(ltx[2][base[2] + i]), e4[i]);
    baud_en = 1'b0; step(3);

    // Reset during the fourth data bit with two words still queued
    for (int k = 0; k < 3; k++) begin din_a = 8'(8'h11 * (k + 1)); wr_a = 1'b1; step(1); end
    wr_a = 1'b0;
    check("t5_level_pre", int'(lvl_a), 2);
    base[0] = nlog[0]; baud_en = 1'b1;
    wait_log(0, 5, 300);
    rst = 1'b1; step(1);
    check("t5_tx", int'(tx_a), 1);
    check("t5_busy", int'(busy_a), 0);
    check("t5_level", int'(lvl_a), 0);
    check("t5_full", int'(full_a), 0);
    rst = 1'b0; step(2);
    base[0] = nlog[0];
    step(300);
    check("t5_no_frame", nlog[0] - base[0], 0);
    check("t5_idle_busy", int'(busy_a), 0);
    baud_en = 1'b0; step(3);

`ifdef TX_BREAK_EN
    // Break for three ticks while 0x10 waits in the FIFO
    sb_a = 1'b1; step(1);
    din_a = 8'h10; wr_a = 1'b1; step(1); wr_a = 1'b0; step(2);
    base[0] = nlog[0]; baud_en = 1'b1;
    wait_log(0, 3, 200);
    sb_a = 1'b0;
    wait_log(0, 15, 400);
    for (int i = 0; i < 15; i++) check("t6_bit", int'(ltx[0][base[0] + i]), e6[i]);
    baud_en = 1'b0; step(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
